flash_responder: RTL

Synthesizable responder for the flash memory controller's parallel ce/oe/we interface. It emulates a small NOR-style flash so the digit-recognizer datapath can be simulated and FPGA-prototyped without an external device. Internally it holds a word-addressed array, serves reads after a fixed access latency, and performs timed program operations. It reports busy/idle on `ready`.

---
 rtl/flash_responder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/flash_responder.sv
// Emulated NOR-style flash behind the ce/oe/we strobe interface: timed reads and programs on a reset-erased array.
// Optional FLASH_AND_PROGRAM_EN: programming ANDs into the stored word (bits only clear); otherwise plain overwrite.
module flash_responder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int READ_LATENCY   = 3,
  parameter int PROGRAM_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  ce,
  input  logic                  oe,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  ready,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int MAXC  = (READ_LATENCY > PROGRAM_CYCLES) ? READ_LATENCY : PROGRAM_CYCLES;
  localparam int CW    = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] RD_INIT = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [CW-1:0] PG_INIT = CW'(PROGRAM_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_VALID, PROG} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nx, dout_nx;
  logic                  dv_nx, err_nx, mem_wr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      data_out   <= dout_nx;
      data_valid <= dv_nx;
      err        <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    dout_nx  = data_out;
    dv_nx    = data_valid;
    err_nx   = 1'b0;
    mem_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (ce && oe && we) begin
          err_nx = 1'b1;
        end else if (ce && oe) begin
          addr_nx = address;
          if (READ_LATENCY == 1) begin
            state_nx = READ_VALID;
          end else begin
            state_nx = READ_WAIT;
            cnt_nx   = RD_INIT;
          end
        end else if (ce && we) begin
          addr_nx  = address;
          wdata_nx = data_in;
          state_nx = PROG;
          cnt_nx   = PG_INIT;
        end
      end
      READ_WAIT: begin
        // Strobe loss wins over a counter that just expired.
        if (!(ce && oe))      state_nx = IDLE;
        else if (cnt == '0)   state_nx = READ_VALID;
        else                  cnt_nx   = cnt - 1'b1;
      end
      READ_VALID: begin
        if (ce && oe) begin
          dv_nx   = 1'b1;
          dout_nx = mem[addr_q];
        end else begin
          state_nx = IDLE;
          dv_nx    = 1'b0;
          dout_nx  = '0;
        end
      end
      PROG: begin
        if (cnt == '0) begin
          mem_wr   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Ready is a pure state decode so an async reset restores it immediately.
  assign ready = (state == IDLE) || (state == READ_VALID);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
    end else if (mem_wr) begin
`ifdef FLASH_AND_PROGRAM_EN
      mem[addr_q] <= mem[addr_q] & wdata_q;
`else
      mem[addr_q] <= wdata_q;
`endif
    end
  end

endmodule
